// File: rtl/cn_serial.sv
// Serial offset-min-sum check node: collects DEG VN->CN messages, then emits DEG CN->VN extrinsics in edge order.
// Latency: first out_valid one cycle after the DEG-th input transfer; one output per handshake after that.
// Backpressure: in_ready low for the whole emit phase; out_msg/out_idx hold while out_valid && !out_ready.
module cn_serial #(
    parameter int MSG_W  = 11,
    parameter int DEG    = 6,
    parameter int IDX_W  = 3,
    parameter int OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MSG_W-1:0] in_msg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MSG_W-1:0] out_msg,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy
);

    localparam logic [MSG_W-2:0] MAX_MAG  = '1;
    localparam logic [MSG_W-2:0] OFF_MAG  = (MSG_W-1)'(OFFSET);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEG-1);

    typedef enum logic {
        COLLECT,
        EMIT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [MSG_W-2:0] min1_q, min1_d;
    logic [MSG_W-2:0] min2_q, min2_d;
    logic [IDX_W-1:0] idx1_q, idx1_d;
    logic             sgn_acc_q, sgn_acc_d;
    logic [DEG-1:0]   signs_q, signs_d;
    logic [MSG_W-1:0] out_msg_q, out_msg_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;

    logic             in_sgn;
    logic [MSG_W-1:0] in_neg;
    logic [MSG_W-2:0] in_mag;
    logic [MSG_W-2:0] mag_sel;
    logic [MSG_W-2:0] mag_off;
    logic             out_sgn;
    logic [MSG_W-1:0] out_pos;

    // Input magnitude; the most-negative code has no positive twin, so it saturates.
    always_comb begin
        in_sgn = in_msg[MSG_W-1];
        in_neg = -in_msg;
        in_mag = in_msg[MSG_W-2:0];
        if (in_sgn) begin
            in_mag = in_neg[MSG_W-1] ? MAX_MAG : in_neg[MSG_W-2:0];
        end
    end

    // Next-state: min tracking during collect, edge stepping during emit.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        min1_d    = min1_q;
        min2_d    = min2_q;
        idx1_d    = idx1_q;
        sgn_acc_d = sgn_acc_q;
        signs_d   = signs_q;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    signs_d[count_q] = in_sgn;
                    sgn_acc_d        = sgn_acc_q ^ in_sgn;
                    if (in_mag < min1_q) begin
                        min2_d = min1_q;
                        min1_d = in_mag;
                        idx1_d = count_q;
                    end else if (in_mag < min2_q) begin
                        min2_d = in_mag;
                    end
                    if (count_q == LAST_IDX) begin
                        state_d = EMIT;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (count_q == LAST_IDX) begin
                        state_d   = COLLECT;
                        count_d   = '0;
                        min1_d    = MAX_MAG;
                        min2_d    = MAX_MAG;
                        idx1_d    = '0;
                        sgn_acc_d = 1'b0;
                        signs_d   = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Output value for the edge the next cycle will present, built from next-state values
    // so the registered output lines up with out_valid and simply holds when no transfer occurs.
    always_comb begin
        mag_sel   = (count_d == idx1_d) ? min2_d : min1_d;
        mag_off   = (mag_sel > OFF_MAG) ? (mag_sel - OFF_MAG) : '0;
        out_sgn   = sgn_acc_d ^ signs_d[count_d];
        out_pos   = {1'b0, mag_off};
        out_msg_d = '0;
        out_idx_d = '0;
        if (state_d == EMIT) begin
            out_msg_d = out_sgn ? -out_pos : out_pos;
            out_idx_d = count_d;
        end
    end

    // State and frame accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= COLLECT;
            count_q   <= '0;
            min1_q    <= MAX_MAG;
            min2_q    <= MAX_MAG;
            idx1_q    <= '0;
            sgn_acc_q <= 1'b0;
            signs_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            min1_q    <= min1_d;
            min2_q    <= min2_d;
            idx1_q    <= idx1_d;
            sgn_acc_q <= sgn_acc_d;
            signs_q   <= signs_d;
        end
    end

    // Registered output message and edge index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_msg_q <= '0;
            out_idx_q <= '0;
        end else begin
            out_msg_q <= out_msg_d;
            out_idx_q <= out_idx_d;
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == EMIT);
    assign out_msg   = out_msg_q;
    assign out_idx   = out_idx_q;
    assign busy      = !((state_q == COLLECT) && (count_q == '0));

endmodule

// File: tb/tb_cn_serial.sv
// Bench for cn_serial: three instances (OFFSET 0, 1, 3) share one input stream and handshake.
// Expected extrinsics come from a direct "min over other edges" model pushed to queues.
module tb_cn_serial;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [10:0] in_msg;
    logic        out_ready;

    logic        in_ready0, out_valid0, busy0;
    logic [10:0] out_msg0;
    logic [2:0]  out_idx0;
    logic        in_ready1, out_valid1, busy1;
    logic [10:0] out_msg1;
    logic [2:0]  out_idx1;
    logic        in_ready3, out_valid3, busy3;
    logic [10:0] out_msg3;
    logic [2:0]  out_idx3;

    int n_cmp = 0;
    int n_err = 0;

    int exp0[$];
    int exp1[$];
    int exp3[$];
    int expi[$];

    int vec1[6] = '{5, -3, 7, 2, -9, 4};
    int vec2[6] = '{6, 6, 6, 6, 6, 6};
    int vec3[6] = '{-1024, 1023, 1023, 1023, 1023, 1023};

    cn_serial #(.MSG_W(11), .DEG(6), .IDX_W(3), .OFFSET(0)) u_off0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_msg(in_msg),
        .out_valid(out_valid0), .out_ready(out_ready), .out_msg(out_msg0), .out_idx(out_idx0),
        .busy(busy0)
    );
    cn_serial #(.MSG_W(11), .DEG(6), .IDX_W(3), .OFFSET(1)) u_off1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_msg(in_msg),
        .out_valid(out_valid1), .out_ready(out_ready), .out_msg(out_msg1), .out_idx(out_idx1),
        .busy(busy1)
    );
    cn_serial #(.MSG_W(11), .DEG(6), .IDX_W(3), .OFFSET(3)) u_off3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_msg(in_msg),
        .out_valid(out_valid3), .out_ready(out_ready), .out_msg(out_msg3), .out_idx(out_idx3),
        .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Extrinsic min-sum reference: for each edge, min |x| and sign product over the other edges.
    function automatic int ref_out(input int v[6], input int j, input int off);
        int mn;
        int sg;
        int a;
        int mag;
        mn = 100000;
        sg = 0;
        for (int i = 0; i < 6; i++) begin
            if (i != j) begin
                a = (v[i] < 0) ? -v[i] : v[i];
                if (a > 1023) a = 1023;
                if (a < mn) mn = a;
                if (v[i] < 0) sg = sg ^ 1;
            end
        end
        mag = mn - off;
        if (mag < 0) mag = 0;
        return (sg != 0) ? -mag : mag;
    endfunction

    task automatic push_frame(input int v[6]);
        for (int j = 0; j < 6; j++) begin
            exp0.push_back(ref_out(v, j, 0));
            exp1.push_back(ref_out(v, j, 1));
            exp3.push_back(ref_out(v, j, 3));
            expi.push_back(j);
        end
    endtask

    task automatic clear_sb();
        exp0.delete();
        exp1.delete();
        exp3.delete();
        expi.delete();
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic push_in(input int v);
        int t;
        in_valid = 1'b1;
        in_msg   = 11'(v);
        for (t = 0; t < 200 && !in_ready0; t++) @(negedge clk);
        if (!in_ready0) begin
            n_cmp++; n_err++;
            $display("FAIL push_in_timeout: in_ready=%0b required 1", in_ready0);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int v[6]);
        for (int i = 0; i < 6; i++) push_in(v[i]);
    endtask

    task automatic wait_drain(input string name);
        int t;
        for (t = 0; t < 200 && (exp0.size() != 0 || out_valid0); t++) @(negedge clk);
        n_cmp++;
        if (exp0.size() != 0 || out_valid0) begin
            n_err++;
            $display("FAIL %s_drain: %0d outputs outstanding, required 0", name, exp0.size());
            clear_sb();
        end
    endtask

    // Scoreboard: compare each output as it is handed over (sampled mid-cycle).
    always begin
        @(negedge clk);
        #1;
        if (!rst && out_valid0 && out_ready) begin
            if (exp0.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_output: idx=%0d msg=%0d, required none", out_idx0, $signed(out_msg0));
            end else begin
                int e0, e1, e3, ei;
                e0 = exp0.pop_front();
                e1 = exp1.pop_front();
                e3 = exp3.pop_front();
                ei = expi.pop_front();
                n_cmp++;
                if (int'($signed(out_idx0)) !== ei && int'(out_idx0) !== ei) begin
                    n_err++;
                    $display("FAIL out_idx: got %0d required %0d", out_idx0, ei);
                end
                n_cmp++;
                if (int'($signed(out_msg0)) !== e0) begin
                    n_err++;
                    $display("FAIL out_msg_off0 idx%0d: got %0d required %0d", ei, $signed(out_msg0), e0);
                end
                n_cmp++;
                if (!out_valid1 || int'($signed(out_msg1)) !== e1 || int'(out_idx1) !== ei) begin
                    n_err++;
                    $display("FAIL out_msg_off1 idx%0d: got %0d/%0d required %0d/%0d", ei, $signed(out_msg1), out_idx1, e1, ei);
                end
                n_cmp++;
                if (!out_valid3 || int'($signed(out_msg3)) !== e3 || int'(out_idx3) !== ei) begin
                    n_err++;
                    $display("FAIL out_msg_off3 idx%0d: got %0d/%0d required %0d/%0d", ei, $signed(out_msg3), out_idx3, e3, ei);
                end
            end
        end
    end

    task automatic test_reset();
        #12;
        n_cmp++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || busy0 !== 1'b0 ||
            out_msg0 !== 11'd0 || out_idx0 !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: vld=%0b rdy=%0b busy=%0b msg=%0d idx=%0d required 0 1 0 0 0",
                     out_valid0, in_ready0, busy0, out_msg0, out_idx0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: vld=%0b rdy=%0b busy=%0b required 0 1 0", out_valid0, in_ready0, busy0);
        end
    endtask

    task automatic test_basic();
        push_frame(vec1);
        for (int i = 0; i < 5; i++) push_in(vec1[i]);
        n_cmp++;
        if (busy0 !== 1'b1 || out_valid0 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_collecting: busy=%0b vld=%0b required 1 0", busy0, out_valid0);
        end
        push_in(vec1[5]);
        n_cmp++;
        if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_latency: vld=%0b rdy=%0b one cycle after 6th accept, required 1 0", out_valid0, in_ready0);
        end
        wait_drain("basic");
    endtask

    task automatic test_frame(input string name, input int v[6]);
        push_frame(v);
        send_frame(v);
        wait_drain(name);
    endtask

    task automatic test_backpressure();
        int t;
        int stalls;
        stalls = 0;
        push_frame(vec1);
        push_frame(vec2);
        out_ready = 1'b0;
        send_frame(vec1);
        in_valid = 1'b1;
        in_msg   = 11'(vec2[0]);
        for (t = 0; t < 100 && out_valid0; t++) begin
            n_cmp++;
            if (in_ready0 !== 1'b0) begin
                n_err++;
                $display("FAIL bp_in_ready: got %0b during emit, required 0", in_ready0);
            end
            if (out_idx0 == 3'd2 && stalls < 3) begin
                out_ready = 1'b0;
                n_cmp++;
                if (out_msg0 !== 11'd2 || out_idx0 !== 3'd2) begin
                    n_err++;
                    $display("FAIL bp_hold stall%0d: msg=%0d idx=%0d required 2 2", stalls, $signed(out_msg0), out_idx0);
                end
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        n_cmp++;
        if (stalls != 3 || out_valid0) begin
            n_err++;
            $display("FAIL bp_sequence: stalls=%0d vld=%0b required 3 0", stalls, out_valid0);
        end
        send_frame(vec2);
        wait_drain("backpressure");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push_in(vec1[i]);
        n_cmp++;
        if (busy0 !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy: got %0b required 1", busy0);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async_reset: vld=%0b rdy=%0b busy=%0b required 0 1 0", out_valid0, in_ready0, busy0);
        end
        @(negedge clk);
        rst = 1'b0;
        test_frame("reset_mid_ties", vec2);

        // Reset while emitting must drop out_valid at once and discard the frame.
        out_ready = 1'b0;
        send_frame(vec1);
        n_cmp++;
        if (out_valid0 !== 1'b1) begin
            n_err++;
            $display("FAIL emit_before_reset: vld=%0b required 1", out_valid0);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid0 !== 1'b0 || out_msg0 !== 11'd0 || in_ready0 !== 1'b1) begin
            n_err++;
            $display("FAIL emit_async_reset: vld=%0b msg=%0d rdy=%0b required 0 0 1", out_valid0, out_msg0, in_ready0);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        test_frame("after_emit_reset", vec2);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_msg    = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_frame("ties", vec2);
        test_frame("saturation", vec3);
        test_frame("offset", vec1);
        test_backpressure();
        test_reset_mid();
        test_frame("back_to_back_a", vec3);
        test_frame("back_to_back_b", vec1);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
